sync_fifo_mem: RTL and testbench



---
 rtl/sync_fifo_mem.sv | 135 +++++++++++++
 tb/tb_sync_fifo_mem.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_mem
//  Brief    : Single-clock FIFO with internal storage, wrap-at-depth pointers,
//             occupancy counter and registered status flags. Defining
//             SYNC_FIFO_ERR_EN adds sticky overflow/underflow outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
    parameter int FIFO_WIDTH    = 29,
    parameter int FIFO_DEPTH    = 128,
    parameter int ADDR_WIDTH    = 7,
    parameter int AFULL_THRESH  = 120,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_ena,
    input  logic [FIFO_WIDTH-1:0] w_data,
    input  logic                  r_ena,
    output logic [FIFO_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH-1:0] c_last_ptr = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_depth    = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_afull    = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   c_aempty   = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   c_one      = (ADDR_WIDTH+1)'(1);

    logic [FIFO_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [FIFO_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Acceptance uses the registered flags, so a full/empty FIFO never races itself.
    assign w_wr_acc = w_ena & ~r_full;
    assign w_rd_acc = r_ena & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_rd_valid <= w_rd_acc;
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == c_depth);
            r_empty    <= (w_count_nxt == '0);
            r_afull    <= (w_count_nxt >= c_afull);
            r_aempty   <= (w_count_nxt <= c_aempty);
        end
    end

    assign r_data       = r_rd_data;
    assign r_valid      = r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ena && r_full) begin
                r_overflow <= 1'b1;
            end
            if (r_ena && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_mem
//  Brief    : Directed self-checking bench for sync_fifo_mem at depth 128 and 5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_mem;

    logic        clk;
    logic        rst;

    logic        w_ena;
    logic [28:0] w_data;
    logic        r_ena;
    logic [28:0] r_data;
    logic        r_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [7:0]  count;

    logic        s_w_ena;
    logic [7:0]  s_w_data;
    logic        s_r_ena;
    logic [7:0]  s_r_data;
    logic        s_r_valid;
    logic        s_full;
    logic        s_empty;
    logic        s_almost_full;
    logic        s_almost_empty;
    logic [3:0]  s_count;

`ifdef SYNC_FIFO_ERR_EN
    logic        overflow;
    logic        underflow;
    logic        s_overflow;
    logic        s_underflow;
`endif

    int n_checks;
    int n_fail;

    sync_fifo_mem #(
        .FIFO_WIDTH    (29),
        .FIFO_DEPTH    (128),
        .ADDR_WIDTH    (7),
        .AFULL_THRESH  (120),
        .AEMPTY_THRESH (8)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .w_ena        (w_ena),
        .w_data       (w_data),
        .r_ena        (r_ena),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    sync_fifo_mem #(
        .FIFO_WIDTH    (8),
        .FIFO_DEPTH    (5),
        .ADDR_WIDTH    (3),
        .AFULL_THRESH  (4),
        .AEMPTY_THRESH (1)
    ) u_dut_small (
        .clk          (clk),
        .rst          (rst),
        .w_ena        (s_w_ena),
        .w_data       (s_w_data),
        .r_ena        (s_r_ena),
        .r_data       (s_r_data),
        .r_valid      (s_r_valid),
        .full         (s_full),
        .empty        (s_empty),
        .almost_full  (s_almost_full),
        .almost_empty (s_almost_empty),
        .count        (s_count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow     (s_overflow),
        .underflow    (s_underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        w_ena    = 1'b0;
        w_data   = '0;
        r_ena    = 1'b0;
        s_w_ena  = 1'b0;
        s_w_data = '0;
        s_r_ena  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_rvalid", 32'(r_valid), 32'd0);
        chk("rst_rdata", 32'(r_data), 32'd0);
        chk("rst_s_empty", 32'(s_empty), 32'd1);

        // Fill 0..127
        for (int i = 0; i < 128; i++) begin
            w_ena  = 1'b1;
            w_data = 29'(i);
            tick();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), ((i + 1) >= 120) ? 32'd1 : 32'd0);
            chk("fill_aempty", 32'(almost_empty), ((i + 1) <= 8) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(full), ((i + 1) == 128) ? 32'd1 : 32'd0);
        end

        // Overflow attempt
        w_data = 29'hABC;
        tick();
        w_ena = 1'b0;
        chk("ovf_count", 32'(count), 32'd128);
        chk("ovf_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_no_uflow", 32'(underflow), 32'd0);
`endif

        // Drain 0..127
        for (int i = 0; i < 128; i++) begin
            r_ena = 1'b1;
            tick();
            chk("drain_valid", 32'(r_valid), 32'd1);
            chk("drain_data", 32'(r_data), 32'(i));
            chk("drain_count", 32'(count), 32'(127 - i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Underflow attempt
        tick();
        r_ena = 1'b0;
        chk("udf_valid", 32'(r_valid), 32'd0);
        chk("udf_count", 32'(count), 32'd0);
        chk("udf_data_hold", 32'(r_data), 32'd127);
`ifdef SYNC_FIFO_ERR_EN
        chk("udf_flag", 32'(underflow), 32'd1);
`endif

        // Simultaneous at empty
        w_ena  = 1'b1;
        r_ena  = 1'b1;
        w_data = 29'h55;
        tick();
        w_ena = 1'b0;
        chk("se_count", 32'(count), 32'd1);
        chk("se_valid", 32'(r_valid), 32'd0);
        chk("se_empty", 32'(empty), 32'd0);
        tick();
        r_ena = 1'b0;
        chk("se_rd_valid", 32'(r_valid), 32'd1);
        chk("se_rd_data", 32'(r_data), 32'h55);
        chk("se_rd_count", 32'(count), 32'd0);

        // Simultaneous at full
        for (int i = 0; i < 128; i++) begin
            w_ena  = 1'b1;
            w_data = 29'(32'h100 + i);
            tick();
        end
        chk("sf_pre_full", 32'(full), 32'd1);
        r_ena  = 1'b1;
        w_data = 29'h1FFF;
        tick();
        w_ena = 1'b0;
        chk("sf_count", 32'(count), 32'd127);
        chk("sf_valid", 32'(r_valid), 32'd1);
        chk("sf_data", 32'(r_data), 32'h100);
        chk("sf_full", 32'(full), 32'd0);
        for (int i = 1; i < 128; i++) begin
            tick();
            chk("sf_drain_data", 32'(r_data), 32'(32'h100 + i));
        end
        r_ena = 1'b0;
        chk("sf_drain_empty", 32'(empty), 32'd1);
        tick();
        chk("sf_no_extra", 32'(r_valid), 32'd0);

        // Reset mid-operation
        for (int i = 0; i < 10; i++) begin
            w_ena  = 1'b1;
            w_data = 29'(32'h200 + i);
            tick();
        end
        chk("mr_pre_count", 32'(count), 32'd10);
        rst   = 1'b1;
        r_ena = 1'b1;
        tick();
        rst   = 1'b0;
        w_ena = 1'b0;
        r_ena = 1'b0;
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_valid", 32'(r_valid), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
        chk("mr_ovf_clr", 32'(overflow), 32'd0);
        chk("mr_udf_clr", 32'(underflow), 32'd0);
`endif
        w_ena  = 1'b1;
        w_data = 29'h777;
        tick();
        w_ena = 1'b0;
        r_ena = 1'b1;
        tick();
        r_ena = 1'b0;
        chk("mr_rd_valid", 32'(r_valid), 32'd1);
        chk("mr_rd_data", 32'(r_data), 32'h777);

        // Depth 5: fill, reject, drain
        for (int i = 0; i < 5; i++) begin
            s_w_ena  = 1'b1;
            s_w_data = 8'(32'hA0 + i);
            tick();
        end
        chk("s_full", 32'(s_full), 32'd1);
        chk("s_full_count", 32'(s_count), 32'd5);
        chk("s_afull", 32'(s_almost_full), 32'd1);
        s_w_data = 8'hEE;
        tick();
        s_w_ena = 1'b0;
        chk("s_ovf_count", 32'(s_count), 32'd5);
        for (int i = 0; i < 5; i++) begin
            s_r_ena = 1'b1;
            tick();
            chk("s_drain_data", 32'(s_r_data), 32'(32'hA0 + i));
        end
        s_r_ena = 1'b0;
        chk("s_drain_empty", 32'(s_empty), 32'd1);

        // Depth 5: 20-word stream with interleaved reads, four wraps
        for (int i = 0; i < 2; i++) begin
            s_w_ena  = 1'b1;
            s_w_data = 8'(32'h30 + i);
            tick();
        end
        for (int i = 2; i < 20; i++) begin
            s_w_ena  = 1'b1;
            s_r_ena  = 1'b1;
            s_w_data = 8'(32'h30 + i);
            tick();
            chk("s_stream_valid", 32'(s_r_valid), 32'd1);
            chk("s_stream_data", 32'(s_r_data), 32'(32'h30 + i - 2));
            chk("s_stream_count", 32'(s_count), 32'd2);
        end
        s_w_ena = 1'b0;
        for (int i = 18; i < 20; i++) begin
            tick();
            chk("s_tail_data", 32'(s_r_data), 32'(32'h30 + i));
        end
        s_r_ena = 1'b0;
        chk("s_tail_empty", 32'(s_empty), 32'd1);
        chk("s_tail_aempty", 32'(s_almost_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
